// File: rtl/aes_encrypt_iter_128.sv
// Iterative AES-128 encryption core: one cipher round per clock with on-the-fly key expansion.
// Define AES_ENC_LAST_KEY_OUT_EN to add the last_round_key port (round key 10 of the last run).
module aes_encrypt_iter_128 (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] plain_text,
    output logic         busy,
    output logic         done,
    output logic [127:0] aes_output,
    output logic [127:0] round_key
`ifdef AES_ENC_LAST_KEY_OUT_EN
    ,
    output logic [127:0] last_round_key
`endif
);

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, RUN} state_t;

    state_t       state, state_next;
    logic [127:0] state_reg, key_reg, next_key, shifted, round_out;
    logic [3:0]   rnd;
    logic         load, last;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte i of the block is row i%4, column i/4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Single shared round datapath; the final round bypasses MixColumns.
    assign next_key  = key_expand(key_reg, rcon(rnd));
    assign shifted   = shift_rows(sub_bytes(state_reg));
    assign round_out = ((rnd == 4'd10) ? shifted : mix_columns(shifted)) ^ next_key;

    assign busy      = (state == RUN);
    assign round_key = key_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (rnd == 4'd10) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= '0;
            key_reg    <= '0;
            rnd        <= '0;
            done       <= 1'b0;
            aes_output <= '0;
`ifdef AES_ENC_LAST_KEY_OUT_EN
            last_round_key <= '0;
`endif
        end else begin
            done <= last;
            if (load) begin
                state_reg <= plain_text ^ key;
                key_reg   <= key;
                rnd       <= 4'd1;
            end else if (state == RUN) begin
                state_reg <= round_out;
                key_reg   <= next_key;
                if (!last) rnd <= rnd + 4'd1;
            end
            if (last) begin
                aes_output <= round_out;
`ifdef AES_ENC_LAST_KEY_OUT_EN
                last_round_key <= next_key;
`endif
            end
        end
    end

endmodule

// File: tb/tb_aes_encrypt_iter_128.sv
// Self-checking bench for aes_encrypt_iter_128: FIPS-197 vectors, random blocks vs. a
// GF(2^8)-derived reference model, back-to-back, ignored start, mid-run reset.
module tb_aes_encrypt_iter_128;

    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] LKB = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [127:0] key, plain_text;
    logic         busy, done;
    logic [127:0] aes_output, round_key;
`ifdef AES_ENC_LAST_KEY_OUT_EN
    logic [127:0] last_round_key;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb [256];

    aes_encrypt_iter_128 dut (
        .clk(clk), .reset(reset), .start(start), .key(key), .plain_text(plain_text),
        .busy(busy), .done(done), .aes_output(aes_output), .round_key(round_key)
`ifdef AES_ENC_LAST_KEY_OUT_EN
        , .last_round_key(last_round_key)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        logic [7:0] xb, inv;
        for (int x = 0; x < 256; x++) begin
            xb  = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic aes_ref(input logic [127:0] k, input logic [127:0] p,
                           output logic [127:0] ct, output logic [127:0] lk);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  s [4][4];
        logic [7:0]  t [4][4];
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = p[127-8*(r+4*c) -: 8] ^ w[c][31-8*r -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sb[s[r][(c+r)%4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (rd < 10)
                        s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                                ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
                    else
                        s[r][c] = t[r][c];
                    s[r][c] = s[r][c] ^ w[4*rd+c][31-8*r -: 8];
                end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                ct[127-8*(r+4*c) -: 8] = s[r][c];
        lk = {w[40], w[41], w[42], w[43]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start(input logic [127:0] k, input logic [127:0] p);
        @(negedge clk);
        key        = k;
        plain_text = p;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        key        = rand128();
        plain_text = rand128();
    endtask

    task automatic run_check(input string tag, input logic [127:0] k, input logic [127:0] p,
                             input logic [127:0] exp_ct, input logic [127:0] exp_lk);
        int   edges;
        logic busy_ok, got;
        edges   = 0;
        busy_ok = 1'b1;
        got     = 1'b0;
        pulse_start(k, p);
        if (busy !== 1'b1) busy_ok = 1'b0;
        while (edges < 30 && !got) begin
            @(posedge clk);
            #1;
            edges++;
            if (done === 1'b1) got = 1'b1;
            else if (busy !== 1'b1) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, 128'(edges), 128'd10);
        check({tag, "_busy_run"}, 128'(busy_ok), 128'd1);
        check({tag, "_busy_done"}, 128'(busy), 128'd0);
        check({tag, "_ct"}, aes_output, exp_ct);
`ifdef AES_ENC_LAST_KEY_OUT_EN
        check({tag, "_lastkey"}, last_round_key, exp_lk);
`else
        if (exp_lk === 128'hx) $display("note: no expected last key");
`endif
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 128'(done), 128'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] m_ct, m_lk, m_lkc;
        logic         ok;
        int           d1, d2, nd, de;

        reset = 1'b1; start = 1'b0; key = '0; plain_text = '0;
        build_sbox();

        aes_ref(KB, PB, m_ct, m_lk);
        check("model_appB_ct", m_ct, CB);
        check("model_appB_lk", m_lk, LKB);
        aes_ref(KC, PC, m_ct, m_lkc);
        check("model_appC_ct", m_ct, CC);

        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", 128'({busy, done}), 128'd0);
        check("rst_out", aes_output, 128'd0);
        check("rst_rk", round_key, 128'd0);
        @(negedge clk);
        reset = 1'b0;

        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if ({busy, done} !== 2'b00 || aes_output !== '0 || round_key !== '0) ok = 1'b0;
`ifdef AES_ENC_LAST_KEY_OUT_EN
            if (last_round_key !== '0) ok = 1'b0;
`endif
        end
        check("idle_20_zero", 128'(ok), 128'd1);

        run_check("appB", KB, PB, CB, LKB);
        run_check("appC", KC, PC, CC, m_lkc);

        for (int i = 0; i < 6; i++) begin
            logic [127:0] rk, rp;
            rk = rand128();
            rp = rand128();
            aes_ref(rk, rp, m_ct, m_lk);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_check($sformatf("rand%0d", i), rk, rp, m_ct, m_lk);
        end

        // back-to-back: start held high, second block offered in the done cycle
        @(negedge clk);
        key = KB; plain_text = PB; start = 1'b1;
        @(posedge clk);
        #1;
        key = KC; plain_text = PC;
        d1 = 0; d2 = 0; ok = 1'b1;
        for (int e = 1; e <= 21; e++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (d1 == 0) d1 = e;
                else if (d2 == 0) d2 = e;
            end
            if (e == 10) check("b2b_ct1", aes_output, CB);
            if (e > 10 && e < 21 && aes_output !== CB) ok = 1'b0;
            if (e == 11) start = 1'b0;
            if (e == 21) check("b2b_ct2", aes_output, CC);
        end
        check("b2b_first_done", 128'(d1), 128'd10);
        check("b2b_period", 128'(d2 - d1), 128'd11);
        check("b2b_hold", 128'(ok), 128'd1);

        // start during RUN is ignored
        pulse_start(KB, PB);
        nd = 0; de = 0;
        for (int e = 1; e <= 25; e++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                nd++;
                de = e;
                check("ign_ct", aes_output, CB);
            end
            if (e == 4) begin key = KC; plain_text = PC; start = 1'b1; end
            if (e == 5) start = 1'b0;
        end
        check("ign_done_count", 128'(nd), 128'd1);
        check("ign_done_edge", 128'(de), 128'd10);

        // reset mid-run
        pulse_start(KB, PB);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mrst_ctl", 128'({busy, done}), 128'd0);
        check("mrst_out", aes_output, 128'd0);
        check("mrst_rk", round_key, 128'd0);
`ifdef AES_ENC_LAST_KEY_OUT_EN
        check("mrst_lk", last_round_key, 128'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) nd++;
        end
        check("mrst_no_done", 128'(nd), 128'd0);
        check("mrst_out_after", aes_output, 128'd0);
        run_check("appB_after_rst", KB, PB, CB, LKB);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
